// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants and state encoding for the keypad entry block
package keypad_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int CNT_W      = 16;

    // One-hot debounce state encoding
    localparam logic [3:0] ST_IDLE       = 4'b0001;
    localparam logic [3:0] ST_PRESS_WAIT = 4'b0010;
    localparam logic [3:0] ST_HELD       = 4'b0100;
    localparam logic [3:0] ST_REL_WAIT   = 4'b1000;

    function automatic logic [31:0] shift_in_digit(input logic [31:0] value,
                                                   input logic [DIGIT_W-1:0] d);
        return {value[31-DIGIT_W:0], d};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - press/release debouncer producing a single accept per key press
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_pressed,
    input  logic [3:0] key_val,
    output logic       accept,
    output logic [3:0] code
);
    import keypad_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;

    // Accept is decoded from the accepting edge itself so the parent can
    // register the digit and its strobe on that same edge.
    always_comb begin
        accept = (state == ST_PRESS_WAIT) && key_pressed && (cnt == LAST);
        code   = key_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_pressed) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!key_pressed) begin
                        state <= ST_IDLE;
                    end else if (cnt == LAST) begin
                        state <= ST_HELD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!key_pressed) begin
                        state <= ST_REL_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_REL_WAIT: begin
                    if (key_pressed) begin
                        state <= ST_HELD;
                    end else if (cnt == LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - hex keypad entry buffer with commit handshake
module keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_DIGITS      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_pressed,
    input  logic [3:0]  key_val,
    input  logic        enter,
    input  logic        clear,
    input  logic        out_ready,
    output logic [31:0] entry,
    output logic [3:0]  digit_cnt,
    output logic        full,
    output logic        key_strobe,
    output logic [31:0] out_value,
    output logic        out_valid,
    output logic        overrun
);
    import keypad_pkg::DIGIT_W;
    import keypad_pkg::shift_in_digit;

    localparam logic [3:0] FULL_CNT = 4'(MAX_DIGITS);

    logic               accept;
    logic [DIGIT_W-1:0] digit;

    logic [31:0] entry_nxt;
    logic [3:0]  cnt_nxt;
    logic [31:0] value_nxt;
    logic        valid_nxt;
    logic        overrun_nxt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .key_pressed(key_pressed),
        .key_val    (key_val),
        .accept     (accept),
        .code       (digit)
    );

    // Priority: clear, then enter, then digit insert; a digit colliding with
    // clear or enter is dropped but still strobes.
    always_comb begin
        entry_nxt   = entry;
        cnt_nxt     = digit_cnt;
        value_nxt   = out_value;
        valid_nxt   = out_valid;
        overrun_nxt = 1'b0;
        if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
        end
        if (clear) begin
            entry_nxt = '0;
            cnt_nxt   = '0;
        end else if (enter) begin
            if (digit_cnt != 4'd0) begin
                if (!out_valid || out_ready) begin
                    value_nxt = entry;
                    valid_nxt = 1'b1;
                    entry_nxt = '0;
                    cnt_nxt   = '0;
                end else begin
                    overrun_nxt = 1'b1;
                end
            end
        end else if (accept && (digit_cnt != FULL_CNT)) begin
            entry_nxt = shift_in_digit(entry, digit);
            cnt_nxt   = digit_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry      <= '0;
            digit_cnt  <= '0;
            full       <= 1'b0;
            key_strobe <= 1'b0;
            out_value  <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            entry      <= entry_nxt;
            digit_cnt  <= cnt_nxt;
            full       <= (cnt_nxt == FULL_CNT);
            key_strobe <= accept;
            out_value  <= value_nxt;
            out_valid  <= valid_nxt;
            overrun    <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - randomized and directed checks against a run-length reference model
module tb_keypad_entry_ctrl;

    localparam int D = 4;

    logic        clk;
    logic        rst;
    logic        key_pressed;
    logic [3:0]  key_val;
    logic        enter;
    logic        clear;
    logic        out_ready;
    logic [31:0] entry;
    logic [3:0]  digit_cnt;
    logic        full;
    logic        key_strobe;
    logic [31:0] out_value;
    logic        out_valid;
    logic        overrun;

    keypad_entry_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .MAX_DIGITS     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_pressed(key_pressed),
        .key_val    (key_val),
        .enter      (enter),
        .clear      (clear),
        .out_ready  (out_ready),
        .entry      (entry),
        .digit_cnt  (digit_cnt),
        .full       (full),
        .key_strobe (key_strobe),
        .out_value  (out_value),
        .out_valid  (out_valid),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: key state as released/held plus the length of the
    // current run of samples that disagree with it; digits kept as a queue.
    bit          m_held;
    int          m_run;
    int          m_digits[$];
    logic [31:0] m_value;
    bit          m_valid;
    bit          m_strobe;
    bit          m_overrun;

    function automatic logic [31:0] model_entry();
        logic [31:0] v = '0;
        foreach (m_digits[i]) v = v * 32'd16 + 32'(m_digits[i]);
        return v;
    endfunction

    task automatic model_step(input bit kp, input int kv, input bit ent, input bit clr,
                              input bit rdy, input bit rs);
        bit acc = 0;
        bit nvalid;
        if (rs) begin
            m_held = 0; m_run = 0; m_digits.delete();
            m_value = '0; m_valid = 0; m_strobe = 0; m_overrun = 0;
            return;
        end
        if (kp != m_held) begin
            m_run++;
            if (m_run == D) begin
                acc = !m_held;
                m_held = kp;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_strobe = acc;
        m_overrun = 0;
        nvalid = m_valid && !rdy;
        if (clr) begin
            m_digits.delete();
        end else if (ent) begin
            if (m_digits.size() > 0) begin
                if (!m_valid || rdy) begin
                    m_value = model_entry();
                    nvalid = 1;
                    m_digits.delete();
                end else begin
                    m_overrun = 1;
                end
            end
        end else if (acc && m_digits.size() < 8) begin
            m_digits.push_back(kv);
        end
        m_valid = nvalid;
    endtask

    task automatic compare_all();
        check("entry", entry, model_entry());
        check("digit_cnt", 32'(digit_cnt), 32'(m_digits.size()));
        check("full", 32'(full), 32'(m_digits.size() == 8));
        check("key_strobe", 32'(key_strobe), 32'(m_strobe));
        check("out_value", out_value, m_value);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_overrun));
    endtask

    task automatic tick(input bit kp, input int kv, input bit ent, input bit clr,
                        input bit rdy, input bit rs);
        key_pressed = kp;
        key_val     = 4'(kv);
        enter       = ent;
        clear       = clr;
        out_ready   = rdy;
        rst         = rs;
        model_step(kp, kv, ent, clr, rdy, rs);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic press_key(input int kv);
        for (int i = 0; i < D; i++) tick(1, kv, 0, 0, 0, 0);
        for (int i = 0; i < D + 1; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    int strobes;
    bit kp_cur;
    int kv_cur;
    int hold_left;
    bit r_ent, r_clr, r_rdy, r_rs;

    initial begin
        key_pressed = 0; key_val = 0; enter = 0; clear = 0; out_ready = 0; rst = 1;
        @(negedge clk);
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        check("reset_entry", entry, 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);

        // Single press held for 10 cycles
        strobes = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1, 3, 0, 0, 0, 0);
            strobes += int'(key_strobe);
            if (i == D) check("press_entry_at_4th", entry, 32'h3);
        end
        for (int i = 0; i < D + 1; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            strobes += int'(key_strobe);
        end
        check("press_one_strobe", 32'(strobes), 32'd1);
        check("press_cnt", 32'(digit_cnt), 32'd1);

        // Bounce then stable press
        tick(0, 0, 0, 1, 0, 0);
        tick(1, 5, 0, 0, 0, 0);
        tick(1, 5, 0, 0, 0, 0);
        tick(0, 5, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(1, 5, 0, 0, 0, 0);
            if (i == 3) check("bounce_not_yet", entry, 32'h0);
        end
        check("bounce_entry", entry, 32'h5);
        for (int i = 0; i < D + 1; i++) tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0);

        // Nine digits: ninth dropped, then commit
        for (int k = 1; k <= 9; k++) press_key(k);
        check("full_entry", entry, 32'h12345678);
        check("full_flag", 32'(full), 32'h1);
        tick(0, 0, 1, 0, 0, 0);
        check("commit_value", out_value, 32'h12345678);
        check("commit_valid", 32'(out_valid), 32'h1);
        check("commit_entry", entry, 32'h0);

        // Refused commit then accepted commit with same-cycle ready
        press_key(10);
        tick(0, 0, 1, 0, 0, 0);
        check("overrun_pulse", 32'(overrun), 32'h1);
        check("overrun_entry", entry, 32'hA);
        tick(0, 0, 1, 0, 1, 0);
        check("reload_value", out_value, 32'hA);
        check("reload_valid", 32'(out_valid), 32'h1);

        // Clear beats enter
        press_key(1);
        press_key(2);
        tick(0, 0, 1, 1, 0, 0);
        check("clr_ent_entry", entry, 32'h0);
        check("clr_ent_valid", 32'(out_valid), 32'h1);
        check("clr_ent_overrun", 32'(overrun), 32'h0);

        // Reset during press wait with key held
        tick(1, 7, 0, 0, 0, 0);
        tick(1, 7, 0, 0, 0, 0);
        tick(1, 7, 0, 0, 0, 1);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_value", out_value, 32'h0);
        for (int i = 1; i <= D; i++) begin
            tick(1, 7, 0, 0, 0, 0);
            if (i == D - 1) check("rst_not_yet", entry, 32'h0);
        end
        check("rst_repress_entry", entry, 32'h7);
        for (int i = 0; i < D + 1; i++) tick(0, 0, 0, 0, 0, 0);

        // Randomized phase
        kp_cur = 0; kv_cur = 0; hold_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold_left == 0) begin
                kp_cur = !kp_cur;
                hold_left = $urandom_range(1, 9);
                if (kp_cur) kv_cur = $urandom_range(0, 15);
            end
            hold_left--;
            if ($urandom_range(0, 7) == 0) kv_cur = $urandom_range(0, 15);
            r_ent = (n < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) == 0);
            r_clr = ($urandom_range(0, 49) == 0);
            r_rdy = ($urandom_range(0, 3) == 0);
            r_rs  = ($urandom_range(0, 399) == 0);
            tick(kp_cur, kv_cur, r_ent, r_clr, r_rdy, r_rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples needed to accept a press or a release; legal range 2..65535.
REQ-002 Parameter MAX_DIGITS, default 8: hex digits held in the entry buffer; fixed at 8 for 32-bit values.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 key_pressed  in  1  scanner level; high while a key is held.
REQ-006 key_val  in  4  scanner hex code, valid while key_pressed is high.
REQ-007 enter  in  1  one-cycle commit request.
REQ-008 clear  in  1  one-cycle entry clear request.
REQ-009 out_ready  in  1  consumer accepts out_value.
REQ-010 entry  out  32  digits typed so far, right-aligned, for seven-segment display.
REQ-011 digit_cnt  out  4  number of digits in entry, 0..8.
REQ-012 full  out  1  high when digit_cnt == 8.
REQ-013 key_strobe  out  1  one-cycle pulse per accepted digit.
REQ-014 out_value  out  32  committed value.
REQ-015 out_valid  out  1  out_value is pending for the consumer.
REQ-016 overrun  out  1  one-cycle pulse when a commit is refused.

Function
REQ-017 The debounce FSM SHALL have four states: IDLE, PRESS_WAIT, HELD and REL_WAIT, with a 16-bit stability counter.
REQ-018 IDLE: key_pressed=1 -> PRESS_WAIT, counter=1; otherwise stay in IDLE.
REQ-019 PRESS_WAIT: key_pressed=0 -> IDLE; key_pressed=1 with counter==DEBOUNCE_CYCLES-1 -> HELD, digit accepted on this edge; otherwise counter+1.
REQ-020 Accept: an accepted digit SHALL be the key_val sampled on the accepting edge, and key_strobe SHALL be high in the following cycle. Net effect: a digit appears in entry on the DEBOUNCE_CYCLES-th consecutive high sample.
REQ-021 HELD: key_pressed=0 -> REL_WAIT, counter=1; otherwise stay in HELD. Holding a key SHALL never produce a second digit.
REQ-022 REL_WAIT: key_pressed=1 -> HELD; key_pressed=0 with counter==DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter+1.
REQ-023 Digit insert: entry <= {entry[27:0], digit} and digit_cnt+1.
REQ-024 Digit insert when full: the digit SHALL be dropped, and entry/digit_cnt SHALL stay unchanged; key_strobe still pulses.
REQ-025 clear: entry=0 and digit_cnt=0 on the next edge; out_value and out_valid are unaffected.
REQ-026 enter with digit_cnt==0: ignored, no overrun.
REQ-027 enter with digit_cnt>0 and out_valid==0, or out_valid==1 and out_ready==1 in the same cycle: out_value<=entry, out_valid<=1, entry<=0, digit_cnt<=0.
REQ-028 enter with digit_cnt>0, out_valid==1 and out_ready==0: refused; entry is kept and overrun pulses one cycle.
REQ-029 Handshake: a transfer occurs when out_valid && out_ready; out_valid then clears unless REQ-027 reloads it the same cycle. out_value SHALL be stable while out_valid is high.
REQ-030 Simultaneous events, priority order:
- clear beats enter; a clear/enter cycle performs only the clear.
- A digit accepted in the same cycle as clear or enter SHALL be dropped (key_strobe still pulses).
REQ-031 out_ready while out_valid is low: no effect.

Reset
REQ-032 On rst=1 at a clock edge:
- debounce FSM goes to IDLE, counter=0.
- entry=0, digit_cnt=0, full=0, key_strobe=0, out_value=0, out_valid=0, overrun=0.
REQ-033 Reset SHALL take effect mid-debounce or mid-handshake. A pending out_value is discarded, and a key still held after reset SHALL be debounced afresh as a new press.

Structure
REQ-034 Shared package keypad_pkg SHALL hold:
- the debounce state encoding (one-hot, 4 bits);
- MAX_DIGITS;
- the digit width constant (4).
REQ-035 The debounce FSM (REQ-017..022) SHALL be a sub-module key_debounce, outputting a one-cycle accept pulse plus the latched code. The entry and commit logic stay in keypad_entry_ctrl.
REQ-036 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Verification (DEBOUNCE_CYCLES=4)
REQ-037 Press key 0x3 for 10 cycles then release -> exactly one key_strobe; entry=0x00000003 after the 4th high sample; digit_cnt=1.
REQ-038 Bounce pattern 1,1,0,1,1,1,1 on key_pressed with key_val=0x5 -> one digit 0x5, accepted on the 4th of the final four high samples only.
REQ-039 Type 1,2,...,9 (nine presses) -> entry=0x12345678, full=1, 9th digit dropped; enter -> out_value=0x12345678, out_valid=1, entry=0.
REQ-040 With out_valid=1 and out_ready=0, type A then enter -> overrun pulse, entry=0x0000000A retained; same cycle enter+out_ready=1 -> out_value=0x0000000A.
REQ-041 clear and enter asserted together with digit_cnt=2 -> entry=0, out_valid unchanged, no overrun.
REQ-042 Assert rst during PRESS_WAIT with key held -> all outputs 0; the held key is accepted DEBOUNCE_CYCLES high samples after reset deasserts.
